// File: rtl/pool_pkg.sv
// Shared types and constants for the max-pooling / max-unpooling blocks.
package pool_pkg;

    localparam int unsigned DEF_SIZE   = 3;
    localparam int unsigned DEF_DATA_W = 16;

    localparam logic [1:0] HIS_TL = 2'd0;
    localparam logic [1:0] HIS_TR = 2'd1;
    localparam logic [1:0] HIS_BL = 2'd2;
    localparam logic [1:0] HIS_BR = 2'd3;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        GRAD    = 2'd1,
        EXPAND  = 2'd2
    } state_e;

    // Window position code of an unpooled coordinate: {row[0], col[0]}.
    function automatic logic [1:0] his_pos(input logic row_lsb, input logic col_lsb);
        return {row_lsb, col_lsb};
    endfunction

endpackage

// File: rtl/max_unpool_if.sv
// Pooler history, gradient input and unpooled output streams of max_unpool.
interface max_unpool_if
    import pool_pkg::*;
#(
    parameter int unsigned SIZE   = DEF_SIZE,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    localparam int unsigned CRD_W = $clog2(2 * SIZE);

    logic              pl_valid;
    logic [15:0]       pl_addr;
    logic [1:0]        pl_history;
    logic              pl_done;
    logic              grad_valid;
    logic [DATA_W-1:0] grad_in;
    logic              grad_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CRD_W-1:0]  out_row;
    logic [CRD_W-1:0]  out_col;
    logic              done_up;

    modport master (
        output pl_valid, pl_addr, pl_history, pl_done,
        output grad_valid, grad_in, out_ready,
        input  grad_ready, out_valid, out_data, out_row, out_col, done_up
    );

    modport slave (
        input  pl_valid, pl_addr, pl_history, pl_done,
        input  grad_valid, grad_in, out_ready,
        output grad_ready, out_valid, out_data, out_row, out_col, done_up
    );

endinterface

// File: rtl/unpool_regfile.sv
// Per-window argmax history and gradient storage; two write ports, one async read.
module unpool_regfile
    import pool_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_SIZE * DEF_SIZE,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = $clog2(DEF_SIZE * DEF_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hist_we_i,
    input  logic [IDX_W-1:0]  hist_waddr_i,
    input  logic [1:0]        hist_wdata_i,
    input  logic              grad_we_i,
    input  logic [IDX_W-1:0]  grad_waddr_i,
    input  logic [DATA_W-1:0] grad_wdata_i,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [1:0]        rd_hist_o,
    output logic [DATA_W-1:0] rd_grad_o
);

    logic [1:0]        hist_q [DEPTH];
    logic [DATA_W-1:0] grad_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= HIS_TL;
        end else if (hist_we_i) begin
            hist_q[hist_waddr_i] <= hist_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) grad_q[i] <= '0;
        end else if (grad_we_i) begin
            grad_q[grad_waddr_i] <= grad_wdata_i;
        end
    end

    assign rd_hist_o = hist_q[rd_addr_i];
    assign rd_grad_o = grad_q[rd_addr_i];

endmodule

// File: rtl/max_unpool.sv
// Max-unpooling: capture pooler argmax history, take SIZE*SIZE gradients,
// then stream the 2*SIZE x 2*SIZE map with each gradient at its max position.
module max_unpool
    import pool_pkg::*;
#(
    parameter int unsigned SIZE   = DEF_SIZE,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    max_unpool_if.slave  bus
);

    localparam int unsigned NPOOL    = SIZE * SIZE;
    localparam int unsigned IDX_W    = (NPOOL > 1) ? $clog2(NPOOL) : 1;
    localparam int unsigned OUT_SIDE = 2 * SIZE;
    localparam int unsigned CRD_W    = $clog2(OUT_SIDE);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [CRD_W-1:0]  orow_q, orow_d;
    logic [CRD_W-1:0]  ocol_q, ocol_d;
    logic              done_up_q, done_up_d;

    logic              hist_we;
    logic              grad_we;
    logic [IDX_W-1:0]  rd_addr;
    logic [1:0]        rd_hist;
    logic [DATA_W-1:0] rd_grad;

    logic              grad_ready_c;
    logic              out_valid_c;
    logic [DATA_W-1:0] out_data_c;
    logic [CRD_W-1:0]  out_row_c;
    logic [CRD_W-1:0]  out_col_c;

    logic grad_last;
    logic ocol_last;
    logic orow_last;

    assign grad_last = (gidx_q == IDX_W'(NPOOL - 1));
    assign ocol_last = (ocol_q == CRD_W'(OUT_SIDE - 1));
    assign orow_last = (orow_q == CRD_W'(OUT_SIDE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CAPTURE;
            gidx_q    <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            done_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            done_up_q <= done_up_d;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        done_up_d = 1'b0;
        unique case (state_q)
            CAPTURE: begin
                if (bus.pl_done) state_d = GRAD;
            end
            GRAD: begin
                if (bus.grad_valid) begin
                    if (grad_last) begin
                        gidx_d  = '0;
                        orow_d  = '0;
                        ocol_d  = '0;
                        state_d = EXPAND;
                    end else begin
                        gidx_d = gidx_q + IDX_W'(1);
                    end
                end
            end
            EXPAND: begin
                if (bus.out_ready) begin
                    if (ocol_last) begin
                        ocol_d = '0;
                        if (orow_last) begin
                            orow_d    = '0;
                            done_up_d = 1'b1;
                            state_d   = CAPTURE;
                        end else begin
                            orow_d = orow_q + CRD_W'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + CRD_W'(1);
                    end
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    // Outputs and register-file strobes, all decoded from registered state.
    always_comb begin
        grad_ready_c = 1'b0;
        out_valid_c  = 1'b0;
        out_data_c   = '0;
        out_row_c    = '0;
        out_col_c    = '0;
        hist_we      = 1'b0;
        grad_we      = 1'b0;
        rd_addr      = IDX_W'((32'(orow_q) >> 1) * SIZE + (32'(ocol_q) >> 1));
        unique case (state_q)
            CAPTURE: begin
                hist_we = bus.pl_valid && (32'(bus.pl_addr) < NPOOL);
            end
            GRAD: begin
                grad_ready_c = 1'b1;
                grad_we      = bus.grad_valid;
            end
            EXPAND: begin
                out_valid_c = 1'b1;
                out_row_c   = orow_q;
                out_col_c   = ocol_q;
                if (rd_hist == his_pos(orow_q[0], ocol_q[0])) out_data_c = rd_grad;
            end
            default: ;
        endcase
    end

    unpool_regfile #(
        .DEPTH  (NPOOL),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .hist_we_i    (hist_we),
        .hist_waddr_i (IDX_W'(bus.pl_addr)),
        .hist_wdata_i (bus.pl_history),
        .grad_we_i    (grad_we),
        .grad_waddr_i (gidx_q),
        .grad_wdata_i (bus.grad_in),
        .rd_addr_i    (rd_addr),
        .rd_hist_o    (rd_hist),
        .rd_grad_o    (rd_grad)
    );

    assign bus.grad_ready = grad_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_data   = out_data_c;
    assign bus.out_row    = out_row_c;
    assign bus.out_col    = out_col_c;
    assign bus.done_up    = done_up_q;

endmodule

// File: tb/tb_max_unpool.sv
// Self-checking bench for max_unpool: model-driven scoreboard plus spot-check table.
module tb_max_unpool;
    import pool_pkg::*;

    localparam int unsigned SIZE   = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = SIZE * SIZE;
    localparam int unsigned SIDE   = 2 * SIZE;

    typedef struct {
        int          r;
        int          c;
        logic [15:0] d;
    } spot_t;

    typedef struct packed {
        logic [2:0]  r;
        logic [2:0]  c;
        logic [15:0] d;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    max_unpool_if #(.SIZE(SIZE), .DATA_W(DATA_W)) bus ();

    max_unpool #(.SIZE(SIZE), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    word_t       sb_q[$];
    logic [1:0]  m_hist [N];
    logic [15:0] m_grad [N];
    logic [1:0]  s_hist [N];
    logic [15:0] s_grad [N];
    logic [15:0] cap [SIDE][SIDE];
    int          xfers        = 0;
    int          valid_cycles = 0;
    int          done_cnt     = 0;
    logic        last_fire    = 1'b0;
    logic        prev_stall   = 1'b0;
    word_t       prev_w;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic check_idle(input string name);
        check({name, "_grad_ready"}, 32'(bus.grad_ready), 0);
        check({name, "_out_valid"},  32'(bus.out_valid), 0);
        check({name, "_done_up"},    32'(bus.done_up), 0);
        check({name, "_out_data"},   32'(bus.out_data), 0);
        check({name, "_out_row"},    32'(bus.out_row), 0);
        check({name, "_out_col"},    32'(bus.out_col), 0);
    endtask

    // Expected raster stream from the bench's own copy of history/gradients.
    task automatic push_expected();
        word_t w;
        for (int r = 0; r < int'(SIDE); r++) begin
            for (int c = 0; c < int'(SIDE); c++) begin
                int p;
                int pos;
                p   = (r / 2) * int'(SIZE) + (c / 2);
                pos = (r % 2) * 2 + (c % 2);
                w.r = 3'(r);
                w.c = 3'(c);
                w.d = (int'(m_hist[p]) == pos) ? m_grad[p] : 16'h0;
                sb_q.push_back(w);
            end
        end
    endtask

    task automatic clear_pl();
        bus.pl_valid   = 1'b0;
        bus.pl_addr    = 16'h0;
        bus.pl_history = 2'd0;
        bus.pl_done    = 1'b0;
    endtask

    task automatic capture(input int n, input bit bogus);
        for (int i = 0; i < n; i++) begin
            bus.pl_valid   = 1'b1;
            bus.pl_addr    = 16'(i);
            bus.pl_history = s_hist[i];
            bus.pl_done    = (i == n - 1);
            if (i == n - 1) check("ready_before_done", 32'(bus.grad_ready), 0);
            m_hist[i] = s_hist[i];
            @(posedge clk); #1;
            if (bogus && i == 0) begin
                bus.pl_addr    = 16'd16;
                bus.pl_history = ~s_hist[0];
                bus.pl_done    = 1'b0;
                @(posedge clk); #1;
            end
        end
        clear_pl();
        check("ready_after_done", 32'(bus.grad_ready), 1);
    endtask

    task automatic feed(input int gap);
        for (int i = 0; i < int'(N); i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.grad_valid = 1'b0;
                bus.pl_valid   = 1'b1;
                bus.pl_addr    = 16'h0;
                bus.pl_history = ~m_hist[0];
                bus.pl_done    = 1'b1;
                @(posedge clk); #1;
            end
            clear_pl();
            if (i == int'(N) - 1) check("valid_before_last_grad", 32'(bus.out_valid), 0);
            bus.grad_valid = 1'b1;
            bus.grad_in    = s_grad[i];
            m_grad[i]      = s_grad[i];
            @(posedge clk); #1;
        end
        bus.grad_valid = 1'b0;
        bus.grad_in    = 16'h0;
        check("valid_after_last_grad", 32'(bus.out_valid), 1);
        push_expected();
    endtask

    task automatic expand(input bit stall, input bit junk, input bit strict_burst);
        int d0;
        d0           = done_cnt;
        xfers        = 0;
        valid_cycles = 0;
        for (int cyc = 0; cyc < 400 && done_cnt == d0; cyc++) begin
            bus.out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (junk) begin
                bus.grad_valid = 1'b1;
                bus.grad_in    = 16'hBEEF;
            end
            @(posedge clk); #1;
        end
        bus.out_ready  = 1'b0;
        bus.grad_valid = 1'b0;
        bus.grad_in    = 16'h0;
        check("done_pulses", 32'(done_cnt - d0), 1);
        check("transfers", 32'(xfers), 32'(4 * N));
        if (strict_burst) check("burst_cycles", 32'(valid_cycles), 32'(4 * N));
        check_idle("post_map");
    endtask

    // Output monitor: scoreboard pop, stall hold, done_up timing.
    initial begin
        word_t cur;
        word_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_fire  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                cur.r = bus.out_row;
                cur.c = bus.out_col;
                cur.d = bus.out_data;
                if (last_fire || bus.done_up) begin
                    check("done_up", 32'(bus.done_up), 32'(last_fire));
                    if (last_fire) check("ready_in_done", 32'(bus.grad_ready), 0);
                end
                if (bus.done_up) done_cnt++;
                if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_w));
                if (bus.out_valid) valid_cycles++;
                last_fire = 1'b0;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %0h expected none", cur);
                    end else begin
                        e = sb_q.pop_front();
                        check("word", 32'(cur), 32'(e));
                        if (cur.r < 3'(SIDE) && cur.c < 3'(SIDE)) cap[cur.r][cur.c] = cur.d;
                        last_fire = (e.r == 3'(SIDE - 1)) && (e.c == 3'(SIDE - 1));
                    end
                    xfers++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_w     = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        spot_t spots [13];
        spots = '{
            '{0, 0, 16'd10}, '{0, 1, 16'd0}, '{0, 2, 16'd0}, '{0, 3, 16'd11}, '{0, 4, 16'd0}, '{0, 5, 16'd0},
            '{1, 0, 16'd0},  '{1, 1, 16'd0}, '{1, 2, 16'd0}, '{1, 3, 16'd0},  '{1, 4, 16'd12}, '{1, 5, 16'd0},
            '{5, 5, 16'd0}
        };

        clear_pl();
        bus.grad_valid = 1'b0;
        bus.grad_in    = 16'h0;
        bus.out_ready  = 1'b0;
        rst            = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            m_hist[i] = 2'd0;
            m_grad[i] = 16'h0;
        end
        #1;
        check_idle("in_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("after_reset");

        // Full map, out_ready held high; includes an out-of-range history write.
        s_hist = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < int'(N); i++) s_grad[i] = 16'(10 + i);
        for (int r = 0; r < int'(SIDE); r++)
            for (int c = 0; c < int'(SIDE); c++) cap[r][c] = 16'hDEAD;
        capture(N, 1'b1);
        feed(0);
        expand(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 13; k++)
            check($sformatf("spot_r%0d_c%0d", spots[k].r, spots[k].c),
                  32'(cap[spots[k].r][spots[k].c]), 32'(spots[k].d));

        // Downstream stalls with a 1,0,0,1 ready pattern; stray grad_valid during EXPAND.
        for (int i = 0; i < int'(N); i++) s_grad[i] = 16'(100 + i);
        capture(N, 1'b0);
        feed(0);
        expand(1'b1, 1'b1, 1'b0);

        // Gradient every third cycle, junk pooler traffic while in GRAD.
        s_hist = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        for (int i = 0; i < int'(N); i++) s_grad[i] = 16'(200 + 7 * i);
        capture(N, 1'b0);
        feed(2);
        expand(1'b0, 1'b0, 1'b1);

        // Early pl_done after 4 entries: indices 4..8 keep the previous history.
        for (int i = 0; i < int'(N); i++) begin
            s_hist[i] = 2'd3;
            s_grad[i] = 16'(300 + i);
        end
        capture(4, 1'b0);
        feed(0);
        expand(1'b0, 1'b0, 1'b1);

        // Reset mid-EXPAND, then a clean full map.
        s_hist = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < int'(N); i++) s_grad[i] = 16'(16'hA000 + 16'(i));
        capture(N, 1'b0);
        feed(0);
        xfers = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && xfers < 20; k++) @(negedge clk);
        check("reach_word_20", 32'(xfers >= 20), 1);
        #2 rst = 1'b1;
        #1;
        check_idle("reset_mid");
        sb_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            m_hist[i] = 2'd0;
            m_grad[i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("after_mid_reset");
        s_hist = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        for (int i = 0; i < int'(N); i++) s_grad[i] = 16'(500 + 3 * i);
        capture(N, 1'b0);
        feed(0);
        expand(1'b0, 1'b0, 1'b1);

        check("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
